radiobox: RTL and testbench
===========================

// Module: radiobox
// PURPOSE
// - Red Pitaya RadioBox peripheral: register block on the sys_bus (20-bit local address window).
// - First functional stage: an operand/adder register set for bus bring-up, plus a DDS1 phase accumulator.
// - Sits beside the scope/ASG blocks and is clocked by the ADC clock domain (125 MHz).
// PARAMETERS
// - RB_ID     32'h52420001  read-only identification word at 0x0C
// - DDS_AW    32            DDS1 phase-accumulator width (fixed 32 in this revision)
// PORTS
// - adc_clk_i    in   1   system/ADC clock, 125 MHz, all logic on rising edge
// - adc_rstn_i   in   1   reset: asynchronous, active-low
// - sys_addr     in   32  bus address; only [19:0] decoded, byte address, word aligned
// - sys_wdata    in   32  bus write data
// - sys_sel      in   4   byte-lane enables for writes (bit n -> wdata[8n+7:8n])
// - sys_wen      in   1   write strobe, single-cycle pulse
// - sys_ren      in   1   read strobe, single-cycle pulse
// - sys_rdata    out  32  read data, valid while sys_ack=1
// - sys_err      out  1   bus error; tied 0
// - sys_ack      out  1   transfer acknowledge, one-cycle pulse
// BEHAVIOUR
// - Reset (async, adc_rstn_i=0): all registers 0, sys_ack=0, sys_rdata=0, sys_err=0, DDS1 accumulator 0.
// - Register map (addr[19:0]):
//   0x00 OP_A      RW 32  adder operand A
//   0x04 OP_B      RW 32  adder operand B
//   0x08 SUM       RO 32  OP_A+OP_B, modulo 2^32 (carry dropped)
//   0x0C ID        RO 32  RB_ID
//   0x10 DDS1_INC  RW 32  phase increment per clock
//   0x14 DDS1_OFS  RW 32  phase offset
//   0x18 DDS1_PH   RO 32  accumulator + DDS1_OFS, modulo 2^32
//   0x1C DDS1_CTL  RW 2   bit0 enable, bit1 reset accumulator (self-clears next cycle)
//   others         read 0, writes ignored, still acked, sys_err stays 0
// - Writes: on the sys_wen cycle, lanes with sys_sel=1 are updated; registers take the new value on that edge.
//   RO addresses ignore writes.
// - Reads: sys_rdata is registered from the decoded address on the sys_ren cycle.
// - Handshake: sys_ack=1 exactly one clock after a sys_wen or sys_ren cycle, for one cycle.
//   If wen and ren arrive together, the write is performed, one ack is given, and the read data reflect
//   the pre-write value.
// - SUM is combinational from the registers: a read issued the cycle after a write to OP_A/OP_B returns
//   the updated sum.
// - DDS1: when CTL.enable=1, acc <= acc + DDS1_INC each clock, wrapping modulo 2^32.
//   CTL.bit1 pulse: acc <= 0 that cycle (has priority over the increment).
//   enable=0: acc holds.
// - Reset mid-transfer: a pending ack is dropped and no register update survives.
// TESTING
// - Write 0x00=15, 0x04=17; read 0x00 -> 15, read 0x04 -> 17, read 0x08 -> 32; each with one ack per access.
// - Write 0x00=32'hFFFF_FFFF, 0x04=2; read 0x08 -> 32'h0000_0001 (wrap, no error).
// - Write 0x00=32'h1234_5678 with sys_sel=4'b0001 over the value 0 -> read 0x00 = 32'h0000_0078.
// - Read 0x0C -> RB_ID; write 0x0C=0 then read -> RB_ID; read 0x40 -> 0 with ack, sys_err=0.
// - DDS1_INC=0x100, CTL=1, run 10 clk, CTL=0; read 0x18 -> 0xA00 ±0x100 (fixed by bus latency);
//   CTL=2 -> read 0x18 = DDS1_OFS.
// - Assert adc_rstn_i low for 10 clks after the adder test; reads of 0x00/0x04/0x08 return 0.

Source files
------------

// File: rtl/radiobox.sv
// radiobox: RadioBox sys_bus register block with operand/adder registers and DDS1 phase accumulator
//   adc_clk_i  : 125 MHz ADC/system clock, all logic on rising edge
//   adc_rstn_i : asynchronous active-low reset
//   sys_addr   : byte address, only [19:0] decoded
//   sys_wdata  : write data, sys_sel picks byte lanes
//   sys_wen    : single-cycle write strobe
//   sys_ren    : single-cycle read strobe
//   sys_rdata  : registered read data, valid while sys_ack
//   sys_err    : always 0
//   sys_ack    : one-cycle acknowledge, one clock after each strobe cycle
module radiobox #(
  parameter logic [31:0] RB_ID  = 32'h52420001,
  parameter int          DDS_AW = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rstn_i,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);
  logic [31:0]       op_a, op_b, rd_mux;
  logic [DDS_AW-1:0] dds_inc, dds_ofs, dds_acc;
  logic              ctl_en, ctl_rst;
  logic [19:0]       a;
  logic              unused_addr;
  assign a           = sys_addr[19:0];
  assign unused_addr = ^sys_addr[31:20];
  assign sys_err     = 1'b0;
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = sel[i] ? wd[8*i+:8] : old[8*i+:8];
    return m;
  endfunction
  always_comb begin
    rd_mux = '0;
    case (a)
      20'h00:  rd_mux = op_a;
      20'h04:  rd_mux = op_b;
      20'h08:  rd_mux = op_a + op_b;
      20'h0C:  rd_mux = RB_ID;
      20'h10:  rd_mux = dds_inc;
      20'h14:  rd_mux = dds_ofs;
      20'h18:  rd_mux = dds_acc + dds_ofs;
      20'h1C:  rd_mux = {30'd0, ctl_rst, ctl_en};
      default: rd_mux = '0;
    endcase
  end
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      op_a      <= '0;
      op_b      <= '0;
      dds_inc   <= '0;
      dds_ofs   <= '0;
      dds_acc   <= '0;
      ctl_en    <= 1'b0;
      ctl_rst   <= 1'b0;
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      // rd_mux sees pre-edge register values, so a combined wen+ren returns the old data
      sys_rdata <= sys_ren ? rd_mux : '0;
      if (sys_wen && a == 20'h00) op_a    <= merge(op_a, sys_wdata, sys_sel);
      if (sys_wen && a == 20'h04) op_b    <= merge(op_b, sys_wdata, sys_sel);
      if (sys_wen && a == 20'h10) dds_inc <= merge(dds_inc, sys_wdata, sys_sel);
      if (sys_wen && a == 20'h14) dds_ofs <= merge(dds_ofs, sys_wdata, sys_sel);
      if (sys_wen && a == 20'h1C && sys_sel[0]) ctl_en <= sys_wdata[0];
      // accumulator clear is a one-cycle pulse; it wins over the increment
      ctl_rst <= sys_wen && a == 20'h1C && sys_sel[0] && sys_wdata[1];
      dds_acc <= ctl_rst ? '0 : ctl_en ? dds_acc + dds_inc : dds_acc;
    end
  end
endmodule

// File: tb/tb_radiobox.sv
// tb_radiobox: self-checking bench for radiobox (vector table, directed corner sequences, random vs model)
module tb_radiobox;
  localparam logic [31:0] ID = 32'h52420001;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  sel = '0;
  logic        wen = 1'b0, ren = 1'b0, err, ack;
  int checks = 0, errors = 0;
  logic [31:0] m_a, m_b, m_inc, m_ofs, m_acc;

  radiobox dut (
    .adc_clk_i(clk), .adc_rstn_i(rstn), .sys_addr(addr), .sys_wdata(wdata),
    .sys_sel(sel), .sys_wen(wen), .sys_ren(ren), .sys_rdata(rdata),
    .sys_err(err), .sys_ack(ack)
  );

  always #4 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_inc = 0; m_ofs = 0; m_acc = 0;
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[19:0])
      20'h00: m_a   = lane_merge(m_a, d, s);
      20'h04: m_b   = lane_merge(m_b, d, s);
      20'h10: m_inc = lane_merge(m_inc, d, s);
      20'h14: m_ofs = lane_merge(m_ofs, d, s);
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    case (a[19:0])
      20'h00:  return m_a;
      20'h04:  return m_b;
      20'h08:  return m_a + m_b;
      20'h0C:  return ID;
      20'h10:  return m_inc;
      20'h14:  return m_ofs;
      20'h18:  return m_acc + m_ofs;
      default: return 0;
    endcase
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr = a; wdata = d; sel = s; wen = 1'b1;
    @(posedge clk); #1 wen = 1'b0;
    check("wr_ack", {31'd0, ack}, 1);
    check("wr_err", {31'd0, err}, 0);
    @(posedge clk); #1;
    check("wr_ack_drop", {31'd0, ack}, 0);
    model_write(a, d, s);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    @(posedge clk); #1 ren = 1'b0;
    check("rd_ack", {31'd0, ack}, 1);
    check("rd_err", {31'd0, err}, 0);
    d = rdata;
    @(posedge clk); #1;
    check("rd_ack_drop", {31'd0, ack}, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t tv[15];
    logic [31:0] d, pre;
    logic [31:0] alist[11];
    tv[0]  = '{1, 32'h00, 32'd15,        4'hF, 0};
    tv[1]  = '{1, 32'h04, 32'd17,        4'hF, 0};
    tv[2]  = '{0, 32'h00, 0,             4'h0, 32'd15};
    tv[3]  = '{0, 32'h04, 0,             4'h0, 32'd17};
    tv[4]  = '{0, 32'h08, 0,             4'h0, 32'd32};
    tv[5]  = '{1, 32'h00, 32'hFFFF_FFFF, 4'hF, 0};
    tv[6]  = '{1, 32'h04, 32'd2,         4'hF, 0};
    tv[7]  = '{0, 32'h08, 0,             4'h0, 32'h0000_0001};
    tv[8]  = '{1, 32'h00, 32'd0,         4'hF, 0};
    tv[9]  = '{1, 32'h00, 32'h1234_5678, 4'h1, 0};
    tv[10] = '{0, 32'h00, 0,             4'h0, 32'h0000_0078};
    tv[11] = '{0, 32'h0C, 0,             4'h0, ID};
    tv[12] = '{1, 32'h0C, 32'd0,         4'hF, 0};
    tv[13] = '{0, 32'h0C, 0,             4'h0, ID};
    tv[14] = '{0, 32'h40, 0,             4'h0, 32'd0};
    alist = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
              32'h40, 32'h7FFFC, 32'h0010_0004};
    model_reset();
    #1;
    check("rst_ack", {31'd0, ack}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", {31'd0, err}, 0);
    idle(3);
    rstn = 1'b1;
    idle(2);
    for (int i = 0; i < 15; i++) begin
      if (tv[i].wr) bus_write(tv[i].a, tv[i].d, tv[i].s);
      else begin
        bus_read(tv[i].a, d);
        check($sformatf("vec%0d_rd_%h", i, tv[i].a), d, tv[i].exp);
      end
    end
    // write and read in the same cycle: old data returned, single ack
    pre = m_a;
    addr = 32'h00; wdata = 32'hAAAA_5555; sel = 4'hF; wen = 1'b1; ren = 1'b1;
    @(posedge clk); #1 wen = 1'b0; ren = 1'b0;
    check("wr_rd_ack", {31'd0, ack}, 1);
    check("wr_rd_old_data", rdata, pre);
    model_write(32'h00, 32'hAAAA_5555, 4'hF);
    idle(1);
    check("wr_rd_single_ack", {31'd0, ack}, 0);
    bus_read(32'h00, d);
    check("wr_rd_new_data", d, 32'hAAAA_5555);
    // reset while an ack is pending
    bus_write(32'h04, 32'h0000_1234, 4'hF);
    addr = 32'h00; wdata = 32'hDEAD_BEEF; sel = 4'hF; wen = 1'b1;
    @(posedge clk); #1 wen = 1'b0;
    rstn = 1'b0;
    #1;
    check("midrst_ack", {31'd0, ack}, 0);
    check("midrst_rdata", rdata, 0);
    idle(10);
    rstn = 1'b1;
    model_reset();
    idle(1);
    bus_read(32'h00, d); check("post_rst_op_a", d, 0);
    bus_read(32'h04, d); check("post_rst_op_b", d, 0);
    bus_read(32'h08, d); check("post_rst_sum", d, 0);
    // DDS1: ten enabled clocks at increment 0x100
    bus_write(32'h10, 32'h100, 4'hF);
    bus_write(32'h1C, 32'd1, 4'hF);
    idle(8);
    bus_write(32'h1C, 32'd0, 4'hF);
    m_acc = 32'hA00;
    bus_read(32'h18, d); check("dds_phase_run", d, 32'hA00);
    bus_read(32'h18, d); check("dds_phase_hold", d, 32'hA00);
    bus_write(32'h14, 32'h55, 4'hF);
    bus_read(32'h18, d); check("dds_phase_ofs", d, 32'hA55);
    bus_write(32'h1C, 32'd2, 4'hF);
    m_acc = 0;
    bus_read(32'h18, d); check("dds_phase_clr", d, 32'h55);
    bus_read(32'h1C, d); check("dds_ctl_selfclr", d, 0);
    // random traffic with the accumulator stopped
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = alist[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1 && a[19:0] != 20'h1C)
        bus_write(a, $urandom, 4'($urandom_range(0, 15)));
      else begin
        bus_read(a, d);
        check($sformatf("rand%0d_rd_%h", i, a), d, model_read(a));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
